dm_sized: RTL and testbench
===========================

Name: dm_sized

Overview:
- Parametrised successor of the single-cycle word data memory: a synchronous data RAM with byte, half-word and word access.
- Provides sign/zero-extended sub-word loads, a valid/ready request handshake and a registered one-cycle read response.
- Includes an alignment-error flag and a hardware clear sequencer that zeroes the array after reset.
- Sits in the MEM stage between the ALU address output and the writeback mux.

Parameters:
- ADDR_W, 10: word-index width; DEPTH = 2**ADDR_W words of 32 bits.
- CLEAR_ON_RESET, 1: 1 = run the clear sequence after reset; 0 = skip it, with array contents undefined after reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- we  input  1  1 = store, 0 = load.
- size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- Addr  input  32  byte address.
- WData  input  32  store data, right-aligned.
- PC  input  32  PC of the requesting instruction (trace only).
- rsp_valid  output  1  response for the request accepted last cycle.
- RData  output  32  load result, extended.
- err  output  1  qualifies rsp_valid: the request was misaligned or reserved.

Behaviour:
- Index is Addr[ADDR_W+1:2]; Addr[31:ADDR_W+2] is ignored, so addresses alias modulo DEPTH*4.
- Accept condition: req_valid & req_ready. Throughput is one request per cycle, with no bubbles between requests.
- Reset asserted: req_ready=0, rsp_valid=0, RData=0, err=0, state=CLEAR (or READY if CLEAR_ON_RESET=0), clr_ptr=0.
- CLEAR state: req_ready=0; one word per cycle, mem[clr_ptr] <= 0, clr_ptr++.
  - After the write to DEPTH-1, go to READY on the next edge; clearing takes exactly DEPTH cycles after reset release.
  - Reset re-asserted mid-clear restarts the sequence from index 0.
- READY state: req_ready=1. Requests presented during CLEAR are ignored and not buffered; the source must hold them.
- Alignment rules:
  - half needs Addr[0]=0; word needs Addr[1:0]=00; byte is always aligned.
  - size=11 is always an error.
- Error request: the memory is not modified. Next cycle rsp_valid=1, err=1, RData=0.
- Store, accepted in cycle N: only the addressed lanes are written at the edge ending cycle N; all other lanes are preserved.
  - Byte: WData[7:0] goes to byte lane Addr[1:0].
  - Half: WData[15:0] goes to lanes {Addr[1],1},{Addr[1],0}.
  - Word: all 32 bits.
  - Cycle N+1: rsp_valid=1, err=0, RData=0.
- Load, accepted in cycle N: the word is read at the edge ending cycle N.
  - Cycle N+1: rsp_valid=1, err=0, RData = selected byte or half, extended per sign_ext.
  - A word load ignores sign_ext.
  - Byte lane 0 = bits 7:0 (little-endian).
- Store in cycle N then load of the same word in cycle N+1: the load returns the post-store value.
- rsp_valid deasserts in any cycle following a non-accepted cycle. RData and err hold their last values while rsp_valid=0.
- There is no response back-pressure; the consumer must take each response in the cycle it is presented.

Optional Feature:
- Macro DM_SIZED_TRACE_EN.
- Defined: each committed store issues $display("%d@%h: *%h <= %h", $time, PC, Addr, merged_word).
  - Addr is forced to word alignment ({Addr[31:2],2'b00}).
  - merged_word is the full 32-bit word after the lane merge.
  - Error requests and loads print nothing.
- Not defined: no display statements are compiled and behaviour is otherwise identical.

Test Plan:
- Clear sequence: ADDR_W=4, release reset. req_ready stays 0 for exactly 16 cycles, then goes to 1. A word load of 0x3C then returns 0x00000000.
- Reset mid-clear: assert reset at clear cycle 7, release it. req_ready rises 16 cycles after the second release.
- Store lane merge: sw 0x11223344 @0x8, then sb 0xAA @0x9, then sh 0xBEEF @0xA. A lw @0x8 then returns 0xBEEFAA44.
- Load extension: with word @0x8 = 0xBEEFAA44, each load returns (next-cycle response):
  - lb @0x9 sign_ext=1 → 0xFFFFFFAA.
  - lb @0x9 sign_ext=0 → 0x000000AA.
  - lh @0xA sign_ext=1 → 0xFFFFBEEF.
  - lbu @0x8 → 0x00000044.
- Misalignment: sw @0x6 and lh @0x3 each give rsp_valid=1, err=1, RData=0, and a subsequent lw @0x4 shows unchanged contents. size=11 @0x0 also gives err=1.
- Back-to-back RAW: sw 0xCAFEF00D @0x20 in cycle N and lw @0x20 in cycle N+1 with req_valid held high. The load response in cycle N+2 is 0xCAFEF00D, and no cycle has req_ready=0.

Source files
------------

// File: rtl/dm_sized.sv
// Sized data memory: byte/half/word loads and stores, valid/ready request, registered response.
// Optional store trace enabled by defining DM_SIZED_TRACE_EN.
module dm_sized #(
  parameter int ADDR_W         = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  input  logic [31:0] PC,
  output logic        rsp_valid,
  output logic [31:0] RData,
  output logic        err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {S_CLEAR, S_READY} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic              misaligned;
  logic              accept;
  logic              store_commit;
  logic [31:0]       old_word;
  logic [3:0]        byte_en;
  logic [31:0]       wdata_rep;
  logic [31:0]       merged_word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_ext;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              unused_bits;

  assign idx         = Addr[ADDR_W+1:2];
  assign lane        = Addr[1:0];
  assign old_word    = mem[idx];
  assign req_ready   = (state_q == S_READY);
  assign accept      = req_valid & req_ready;
  assign unused_bits = ^{PC, Addr[31:ADDR_W+2]};

  always_comb begin
    misaligned = 1'b0;
    byte_en    = 4'b0000;
    wdata_rep  = WData;
    case (size)
      2'b00: begin
        byte_en   = 4'b0001 << lane;
        wdata_rep = {4{WData[7:0]}};
      end
      2'b01: begin
        misaligned = Addr[0];
        byte_en    = Addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{WData[15:0]}};
      end
      2'b10: begin
        misaligned = |Addr[1:0];
        byte_en    = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  assign store_commit = accept & we & ~misaligned;

  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) merged_word[8*i +: 8] = wdata_rep[8*i +: 8];
    end
  end

  // Lane select and extension; a word load passes the raw word regardless of sign_ext.
  always_comb begin
    byte_sel = old_word[{lane, 3'b000} +: 8];
    half_sel = Addr[1] ? old_word[31:16] : old_word[15:0];
    case (size)
      2'b00:   load_ext = sign_ext ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
      2'b01:   load_ext = sign_ext ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
      default: load_ext = old_word;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    mem_we    = store_commit;
    mem_waddr = idx;
    mem_wdata = merged_word;
    if (state_q == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_ptr_q;
      mem_wdata = 32'b0;
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == {ADDR_W{1'b1}}) state_d = S_READY;
    end
  end

  // Response fields hold their last value through idle cycles.
  always_comb begin
    rsp_valid_d = accept;
    err_d       = err_q;
    rdata_d     = rdata_q;
    if (accept) begin
      err_d   = misaligned;
      rdata_d = (!we && !misaligned) ? load_ext : 32'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
      clr_ptr_q   <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

`ifdef DM_SIZED_TRACE_EN
  always @(posedge clk) begin
    if (reset && store_commit)
      $display("%d@%h: *%h <= %h", $time, PC, {Addr[31:2], 2'b00}, merged_word);
  end
`else
`endif

  assign rsp_valid = rsp_valid_q;
  assign err       = err_q;
  assign RData     = rdata_q;

endmodule

// File: tb/tb_dm_sized.sv
// Directed self-checking bench for dm_sized with a 16-word array.
module tb_dm_sized;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        we;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] Addr;
   logic [31:0] WData;
   logic [31:0] PC;
   logic        rsp_valid;
   logic [31:0] RData;
   logic        err;

   int checkCount;
   int passCount;
   int clearCycles;

   dm_sized #(.ADDR_W(4), .CLEAR_ON_RESET(1'b1)) dut (
      .clk(clk),
      .reset(reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .we(we),
      .size(size),
      .sign_ext(sign_ext),
      .Addr(Addr),
      .WData(WData),
      .PC(PC),
      .rsp_valid(rsp_valid),
      .RData(RData),
      .err(err)
   );

   // Free-running clock, 10 time units per period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every comparison in the bench funnels through here
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
      checkCount++;
      if (got === expected) passCount++;
      else $display("[TB] FAIL %s: got %h, expected %h", tag, got, expected);
   endtask

   // Presents one request for a single edge and returns at the following negedge,
   // where the response of that request is visible and the next request can be driven
   task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic sx,
                                input logic [31:0] a, input logic [31:0] d);
      req_valid = 1'b1;
      we        = w;
      size      = sz;
      sign_ext  = sx;
      Addr      = a;
      WData     = d;
      PC        = PC + 32'd4;
      checkOutput("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
   endtask

   // Checks the response produced by the request issued just before
   task automatic expectRsp(input string tag, input logic expErr, input logic [31:0] expData);
      checkOutput({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
      checkOutput({tag, "_err"}, {31'b0, err}, {31'b0, expErr});
      checkOutput({tag, "_rdata"}, RData, expData);
   endtask

   // Drops req_valid for one full cycle
   task automatic idleCycle();
      req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Counts cycles from reset release until req_ready rises, bounded
   task automatic countClear(output int n);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         n++;
         if (req_ready) break;
      end
   endtask

   // Hard stop in case something stalls the main sequence
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main directed sequence
   initial begin
      checkCount = 0;
      passCount  = 0;
      reset      = 1'b0;
      req_valid  = 1'b0;
      we         = 1'b0;
      size       = 2'b00;
      sign_ext   = 1'b0;
      Addr       = 32'h0;
      WData      = 32'h0;
      PC         = 32'h0000_1000;

      repeat (3) @(negedge clk);
      checkOutput("reset_req_ready", {31'b0, req_ready}, 32'd0);
      checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      checkOutput("reset_rdata", RData, 32'd0);
      checkOutput("reset_err", {31'b0, err}, 32'd0);

      reset = 1'b1;
      countClear(clearCycles);
      checkOutput("clear_cycles", clearCycles, 32'd16);

      applyStimulus(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0);
      idleCycle();
      checkOutput("lw_3C_after_clear", RData, 32'h0);

      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (7) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("midclear_reset_ready", {31'b0, req_ready}, 32'd0);
      reset = 1'b1;
      countClear(clearCycles);
      checkOutput("midclear_cycles", clearCycles, 32'd16);

      applyStimulus(1'b1, 2'b10, 1'b0, 32'h8, 32'h11223344);
      expectRsp("sw_8", 1'b0, 32'h0);
      applyStimulus(1'b1, 2'b00, 1'b0, 32'h9, 32'h000000AA);
      expectRsp("sb_9", 1'b0, 32'h0);
      applyStimulus(1'b1, 2'b01, 1'b0, 32'hA, 32'h0000BEEF);
      expectRsp("sh_A", 1'b0, 32'h0);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
      expectRsp("lw_8_merged", 1'b0, 32'hBEEFAA44);

      applyStimulus(1'b0, 2'b00, 1'b1, 32'h9, 32'h0);
      expectRsp("lb_9", 1'b0, 32'hFFFFFFAA);
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h9, 32'h0);
      expectRsp("lbu_9", 1'b0, 32'h000000AA);
      applyStimulus(1'b0, 2'b01, 1'b1, 32'hA, 32'h0);
      expectRsp("lh_A", 1'b0, 32'hFFFFBEEF);
      applyStimulus(1'b0, 2'b01, 1'b0, 32'hA, 32'h0);
      expectRsp("lhu_A", 1'b0, 32'h0000BEEF);
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h8, 32'h0);
      expectRsp("lbu_8", 1'b0, 32'h00000044);
      applyStimulus(1'b0, 2'b10, 1'b1, 32'h48, 32'h0);
      expectRsp("lw_alias_48", 1'b0, 32'hBEEFAA44);

      idleCycle();
      checkOutput("idle_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      checkOutput("idle_rdata_hold", RData, 32'hBEEFAA44);

      applyStimulus(1'b1, 2'b10, 1'b0, 32'h4, 32'h55667788);
      expectRsp("sw_4", 1'b0, 32'h0);
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h6, 32'hDEADBEEF);
      expectRsp("sw_6_misaligned", 1'b1, 32'h0);
      applyStimulus(1'b0, 2'b01, 1'b1, 32'h3, 32'h0);
      expectRsp("lh_3_misaligned", 1'b1, 32'h0);
      applyStimulus(1'b1, 2'b11, 1'b0, 32'h0, 32'hFFFFFFFF);
      expectRsp("size11_0", 1'b1, 32'h0);
      idleCycle();
      checkOutput("idle_err_hold", {31'b0, err}, 32'd1);
      checkOutput("idle_rsp_valid_after_err", {31'b0, rsp_valid}, 32'd0);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
      expectRsp("lw_4_unchanged", 1'b0, 32'h55667788);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
      expectRsp("lw_0_unchanged", 1'b0, 32'h0);

      applyStimulus(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D);
      expectRsp("raw_sw_20", 1'b0, 32'h0);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
      expectRsp("raw_lw_20", 1'b0, 32'hCAFEF00D);
      idleCycle();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
